// File: rtl/bsg_1hold_rr_ctrl_pkg.sv
// Shared types for the single-slot round-robin hold controller.
// The slot typedef is a macro so each instance can size id/data from its own parameters.
`ifndef BSG_1HOLD_RR_CTRL_PKG_SV
`define BSG_1HOLD_RR_CTRL_PKG_SV

`define BSG_1HOLD_SLOT_T(name_t, id_w, data_w) \
    typedef struct packed { \
        logic              v; \
        logic [(id_w)-1:0] id; \
        logic [(data_w)-1:0] data; \
    } name_t

package bsg_1hold_rr_ctrl_pkg;

    typedef enum logic {
        e_idle  = 1'b0,
        e_burst = 1'b1
    } state_e;

endpackage

`endif

// File: rtl/bsg_rr_pick.sv
// Combinational rotating-priority picker: lowest-index request at or above ptr wins,
// otherwise the lowest-index request overall.
module bsg_rr_pick #(
    parameter  int els_p     = 4,
    localparam int lg_els_lp = $clog2(els_p)
) (
    input  logic [els_p-1:0]     req,
    input  logic [lg_els_lp-1:0] ptr,
    output logic [els_p-1:0]     grant,
    output logic [lg_els_lp-1:0] idx,
    output logic                 any
);

    logic [els_p-1:0] hi_req;
    logic [els_p-1:0] hi_grant;
    logic [els_p-1:0] lo_grant;
    logic             hi_found;
    logic             lo_found;

    generate
        for (genvar gi = 0; gi < els_p; gi++) begin : g_hi_mask
            assign hi_req[gi] = req[gi] & (gi >= int'(ptr));
        end
    endgenerate

    always_comb begin
        hi_grant = '0;
        lo_grant = '0;
        hi_found = 1'b0;
        lo_found = 1'b0;
        for (int k = 0; k < els_p; k++) begin
            if (hi_req[k] && !hi_found) begin
                hi_grant[k] = 1'b1;
                hi_found    = 1'b1;
            end
            if (req[k] && !lo_found) begin
                lo_grant[k] = 1'b1;
                lo_found    = 1'b1;
            end
        end
    end

    // Requests at or above ptr take priority; otherwise wrap to the bottom.
    assign grant = hi_found ? hi_grant : lo_grant;
    assign any   = lo_found;

    always_comb begin
        idx = '0;
        for (int k = 0; k < els_p; k++) begin
            if (grant[k]) begin
                idx = idx | lg_els_lp'(k);
            end
        end
    end

endmodule

// File: rtl/bsg_1hold_rr_ctrl.sv
// Round-robin scheduler with optional burst locking feeding one registered output slot
// that holds its beat bit-exact while the consumer stalls.
module bsg_1hold_rr_ctrl
    import bsg_1hold_rr_ctrl_pkg::*;
#(
    parameter  int els_p        = 4,
    parameter  int data_width_p = 32,
    parameter  int burst_len_p  = 1,
    localparam int lg_els_lp    = $clog2(els_p),
    localparam int lg_burst_lp  = $clog2(burst_len_p + 1)
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    input  logic [els_p-1:0]              v_i,
    input  logic [els_p*data_width_p-1:0] data_i,
    output logic [els_p-1:0]              yumi_o,
    output logic                          v_o,
    output logic [data_width_p-1:0]       data_o,
    output logic [lg_els_lp-1:0]          id_o,
    input  logic                          stall_i
);

    `BSG_1HOLD_SLOT_T(slot_t, lg_els_lp, data_width_p);

    slot_t                  slot_reg, slot_next;
    state_e                 state_reg, state_next;
    logic [lg_els_lp-1:0]   ptr_reg, ptr_next;
    logic [lg_els_lp-1:0]   owner_reg, owner_next;
    logic [lg_burst_lp-1:0] cnt_reg, cnt_next;

    logic                   adv;
    logic [lg_els_lp-1:0]   owner_inc;
    logic [lg_els_lp-1:0]   pick_ptr;
    logic [els_p-1:0]       pick_grant;
    logic [lg_els_lp-1:0]   pick_idx;
    logic                   pick_any;
    logic [els_p-1:0]       yumi_int;
    logic                   grant_v;
    logic [lg_els_lp-1:0]   grant_idx;

    function automatic logic [lg_els_lp-1:0] wrap_inc(input logic [lg_els_lp-1:0] i);
        if (i == lg_els_lp'(els_p - 1)) begin
            return '0;
        end
        return i + lg_els_lp'(1);
    endfunction

    // An empty slot always fills, even under stall; a full one advances only when consumed.
    assign adv       = ~slot_reg.v | ~stall_i;
    assign owner_inc = wrap_inc(owner_reg);

    // When a burst owner drops out, re-arbitrate in the same cycle starting just past it.
    assign pick_ptr = (state_reg == e_burst) ? owner_inc : ptr_reg;

    bsg_rr_pick #(
        .els_p(els_p)
    ) u_pick (
        .req  (v_i),
        .ptr  (pick_ptr),
        .grant(pick_grant),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        owner_next = owner_reg;
        cnt_next   = cnt_reg;
        yumi_int   = '0;
        grant_v    = 1'b0;
        grant_idx  = pick_idx;

        if (adv) begin
            if (state_reg == e_burst && v_i[owner_reg]) begin
                grant_v             = 1'b1;
                grant_idx           = owner_reg;
                yumi_int[owner_reg] = 1'b1;
                if (cnt_reg == lg_burst_lp'(burst_len_p - 1)) begin
                    state_next = e_idle;
                    ptr_next   = owner_inc;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + lg_burst_lp'(1);
                end
            end else begin
                if (state_reg == e_burst) begin
                    state_next = e_idle;
                    ptr_next   = owner_inc;
                    cnt_next   = '0;
                end
                if (pick_any) begin
                    grant_v   = 1'b1;
                    grant_idx = pick_idx;
                    yumi_int  = pick_grant;
                    if (burst_len_p == 1) begin
                        ptr_next = wrap_inc(pick_idx);
                    end else begin
                        owner_next = pick_idx;
                        cnt_next   = lg_burst_lp'(1);
                        state_next = e_burst;
                    end
                end
            end
        end
    end

    // On an advance without a grant only v drops; id/data keep their last values.
    always_comb begin
        slot_next = slot_reg;
        if (adv) begin
            slot_next.v = grant_v;
            if (grant_v) begin
                slot_next.id   = grant_idx;
                slot_next.data = data_i[int'(grant_idx)*data_width_p +: data_width_p];
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            slot_reg  <= '0;
            state_reg <= e_idle;
            ptr_reg   <= '0;
            owner_reg <= '0;
            cnt_reg   <= '0;
        end else begin
            slot_reg  <= slot_next;
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            owner_reg <= owner_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign yumi_o = reset_n_i ? yumi_int : '0;
    assign v_o    = slot_reg.v;
    assign data_o = slot_reg.data;
    assign id_o   = slot_reg.id;

`ifndef SYNTHESIS
    always @(negedge clk_i) begin
        if (reset_n_i) begin
            if ($isunknown(stall_i)) begin
                $error("bsg_1hold_rr_ctrl: stall_i is X out of reset");
                $finish;
            end
            if (!$onehot0(yumi_o)) begin
                $error("bsg_1hold_rr_ctrl: yumi_o not one-hot0 (%b)", yumi_o);
                $finish;
            end
            if ((yumi_o & ~v_i) != '0) begin
                $error("bsg_1hold_rr_ctrl: yumi_o %b grants invalid requester (v_i %b)", yumi_o, v_i);
                $finish;
            end
        end
    end
`endif

endmodule

// File: tb/tb_bsg_1hold_rr_ctrl.sv
// Scoreboarded bench: one instance in pure round-robin, one with bursts of three.
module tb_bsg_1hold_rr_ctrl;

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] data;
    } beat_t;

    logic         clk;
    logic         rst1, rst3;
    logic [3:0]   v1, v3;
    logic [127:0] data1, data3;
    logic         stall1, stall3;
    logic [3:0]   yumi_o1, yumi_o3;
    logic         v_o1, v_o3;
    logic [31:0]  data_o1, data_o3;
    logic [1:0]   id_o1, id_o3;

    beat_t q1[$];
    beat_t q3[$];
    beat_t e1, e3;
    int tests_run    = 0;
    int tests_failed = 0;

    bsg_1hold_rr_ctrl #(.els_p(4), .data_width_p(32), .burst_len_p(1)) dut1 (
        .clk_i(clk), .reset_n_i(rst1), .v_i(v1), .data_i(data1), .yumi_o(yumi_o1),
        .v_o(v_o1), .data_o(data_o1), .id_o(id_o1), .stall_i(stall1)
    );

    bsg_1hold_rr_ctrl #(.els_p(4), .data_width_p(32), .burst_len_p(3)) dut3 (
        .clk_i(clk), .reset_n_i(rst3), .v_i(v3), .data_i(data3), .yumi_o(yumi_o3),
        .v_o(v_o3), .data_o(data_o3), .id_o(id_o3), .stall_i(stall3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // A beat leaves the slot on any cycle it is valid and not stalled.
    always @(negedge clk) begin
        if (rst1 && v_o1 && !stall1) begin
            tests_run++;
            if (q1.size() == 0) begin
                tests_failed++;
                $display("FAIL mon1_extra: got id=%0d data=%h, required no beat", id_o1, data_o1);
            end else begin
                e1 = q1.pop_front();
                if (id_o1 !== e1.id || data_o1 !== e1.data) begin
                    tests_failed++;
                    $display("FAIL mon1_beat: got id=%0d data=%h, required id=%0d data=%h",
                             id_o1, data_o1, e1.id, e1.data);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst3 && v_o3 && !stall3) begin
            tests_run++;
            if (q3.size() == 0) begin
                tests_failed++;
                $display("FAIL mon3_extra: got id=%0d data=%h, required no beat", id_o3, data_o3);
            end else begin
                e3 = q3.pop_front();
                if (id_o3 !== e3.id || data_o3 !== e3.data) begin
                    tests_failed++;
                    $display("FAIL mon3_beat: got id=%0d data=%h, required id=%0d data=%h",
                             id_o3, data_o3, e3.id, e3.data);
                end
            end
        end
    end

    task automatic step1(input logic [3:0] v, input logic s);
        @(posedge clk); #1;
        v1 = v; stall1 = s;
        @(negedge clk); #1;
    endtask

    task automatic step3(input logic [3:0] v, input logic s);
        @(posedge clk); #1;
        v3 = v; stall3 = s;
        @(negedge clk); #1;
    endtask

    task automatic test_reset();
        rst1 = 1'b0; rst3 = 1'b0;
        v1 = 4'b1111; v3 = 4'b1111; stall1 = 1'b0; stall3 = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        tests_run += 4;
        if (yumi_o1 !== 4'b0000 || yumi_o3 !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_yumi: got %b/%b, required 0000", yumi_o1, yumi_o3);
        end
        if (v_o1 !== 1'b0 || v_o3 !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_v: got %b/%b, required 0", v_o1, v_o3);
        end
        if (data_o1 !== 32'h0 || data_o3 !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_data: got %h/%h, required 0", data_o1, data_o3);
        end
        if (id_o1 !== 2'd0 || id_o3 !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_id: got %0d/%0d, required 0", id_o1, id_o3);
        end
        @(posedge clk); #1;
        v1 = 4'b0000; v3 = 4'b0000;
        rst1 = 1'b1; rst3 = 1'b1;
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_y;
        beat_t b;
        for (int k = 0; k < 5; k++) begin
            step1(4'b1111, 1'b0);
            exp_y = 4'b0001 << (k % 4);
            tests_run++;
            if (yumi_o1 !== exp_y) begin
                tests_failed++;
                $display("FAIL rr_yumi[%0d]: got %b, required %b", k, yumi_o1, exp_y);
            end
            if (k > 0) begin
                tests_run++;
                if (v_o1 !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL rr_bubble[%0d]: got v_o=%b, required 1", k, v_o1);
                end
            end
            b.id = 2'(k % 4);
            b.data = data1[(k % 4)*32 +: 32];
            q1.push_back(b);
        end
        step1(4'b0000, 1'b0);
        tests_run++;
        if (yumi_o1 !== 4'b0000) begin
            tests_failed++;
            $display("FAIL rr_idle_yumi: got %b, required 0000", yumi_o1);
        end
        step1(4'b0000, 1'b0);
        tests_run++;
        if (v_o1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL rr_drain_v: got %b, required 0", v_o1);
        end
    endtask

    task automatic test_hold();
        beat_t b;
        data1[2*32 +: 32] = 32'hA5;
        step1(4'b0100, 1'b0);
        tests_run++;
        if (yumi_o1 !== 4'b0100) begin
            tests_failed++;
            $display("FAIL hold_load_yumi: got %b, required 0100", yumi_o1);
        end
        b.id = 2'd2; b.data = 32'hA5;
        q1.push_back(b);
        for (int k = 0; k < 3; k++) begin
            step1(4'b0010, 1'b1);
            tests_run += 2;
            if (v_o1 !== 1'b1 || data_o1 !== 32'hA5 || id_o1 !== 2'd2) begin
                tests_failed++;
                $display("FAIL hold_slot[%0d]: got v=%b id=%0d data=%h, required v=1 id=2 data=a5",
                         k, v_o1, id_o1, data_o1);
            end
            if (yumi_o1 !== 4'b0000) begin
                tests_failed++;
                $display("FAIL hold_yumi[%0d]: got %b, required 0000", k, yumi_o1);
            end
        end
        step1(4'b0010, 1'b0);
        tests_run++;
        if (yumi_o1 !== 4'b0010) begin
            tests_failed++;
            $display("FAIL hold_release_yumi: got %b, required 0010", yumi_o1);
        end
        b.id = 2'd1; b.data = data1[1*32 +: 32];
        q1.push_back(b);
        step1(4'b0000, 1'b0);
        tests_run++;
        if (v_o1 !== 1'b1) begin
            tests_failed++;
            $display("FAIL hold_next_v: got %b, required 1", v_o1);
        end
        step1(4'b0000, 1'b0);
    endtask

    task automatic test_bubble_fill();
        beat_t b;
        step1(4'b0100, 1'b1);
        tests_run += 2;
        if (v_o1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL bubble_pre_v: got %b, required 0", v_o1);
        end
        if (yumi_o1 !== 4'b0100) begin
            tests_failed++;
            $display("FAIL bubble_yumi: got %b, required 0100", yumi_o1);
        end
        b.id = 2'd2; b.data = data1[2*32 +: 32];
        q1.push_back(b);
        step1(4'b0010, 1'b1);
        tests_run += 2;
        if (v_o1 !== 1'b1 || id_o1 !== 2'd2 || data_o1 !== 32'hA5) begin
            tests_failed++;
            $display("FAIL bubble_slot: got v=%b id=%0d data=%h, required v=1 id=2 data=a5",
                     v_o1, id_o1, data_o1);
        end
        if (yumi_o1 !== 4'b0000) begin
            tests_failed++;
            $display("FAIL bubble_stall_yumi: got %b, required 0000", yumi_o1);
        end
        step1(4'b0000, 1'b0);
        step1(4'b0000, 1'b0);
        tests_run++;
        if (v_o1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL bubble_drain_v: got %b, required 0", v_o1);
        end
    endtask

    task automatic test_burst();
        logic [3:0] v_tab  [11] = '{4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0011,
                                   4'b0011, 4'b0010, 4'b0011, 4'b0011, 4'b0011};
        int         id_tab [11] = '{0, 0, 0, 1, 1, 1, 0, 1, 1, 1, 0};
        logic [3:0] exp_y;
        beat_t b;
        for (int k = 0; k < 11; k++) begin
            step3(v_tab[k], 1'b0);
            exp_y = 4'b0001 << id_tab[k];
            tests_run++;
            if (yumi_o3 !== exp_y) begin
                tests_failed++;
                $display("FAIL burst_yumi[%0d]: got %b, required %b", k, yumi_o3, exp_y);
            end
            b.id = 2'(id_tab[k]);
            b.data = data3[id_tab[k]*32 +: 32];
            q3.push_back(b);
        end
        step3(4'b0000, 1'b0);
        step3(4'b0000, 1'b0);
        tests_run++;
        if (v_o3 !== 1'b0) begin
            tests_failed++;
            $display("FAIL burst_drain_v: got %b, required 0", v_o3);
        end
    endtask

    task automatic test_reset_mid_burst();
        beat_t b;
        for (int k = 0; k < 2; k++) begin
            step3(4'b0010, 1'b0);
            tests_run++;
            if (yumi_o3 !== 4'b0010) begin
                tests_failed++;
                $display("FAIL midrst_pre_yumi[%0d]: got %b, required 0010", k, yumi_o3);
            end
            b.id = 2'd1; b.data = data3[1*32 +: 32];
            q3.push_back(b);
        end
        rst3 = 1'b0;
        #1;
        tests_run += 2;
        if (v_o3 !== 1'b0 || id_o3 !== 2'd0 || data_o3 !== 32'h0) begin
            tests_failed++;
            $display("FAIL midrst_slot: got v=%b id=%0d data=%h, required all 0", v_o3, id_o3, data_o3);
        end
        if (yumi_o3 !== 4'b0000) begin
            tests_failed++;
            $display("FAIL midrst_yumi: got %b, required 0000", yumi_o3);
        end
        q3.delete();
        v3 = 4'b0000;
        @(posedge clk); #1;
        rst3 = 1'b1;
        step3(4'b0011, 1'b0);
        tests_run++;
        if (yumi_o3 !== 4'b0001) begin
            tests_failed++;
            $display("FAIL midrst_first_grant: got %b, required 0001", yumi_o3);
        end
        b.id = 2'd0; b.data = data3[0 +: 32];
        q3.push_back(b);
        step3(4'b0000, 1'b0);
        step3(4'b0000, 1'b0);
    endtask

    initial begin
        data1 = {32'h0000_0103, 32'h0000_0102, 32'h0000_0101, 32'h0000_0100};
        data3 = {32'h0000_0303, 32'h0000_0302, 32'h0000_0301, 32'h0000_0300};
        test_reset();
        test_round_robin();
        test_hold();
        test_bubble_fill();
        test_burst();
        test_reset_mid_burst();
        tests_run++;
        if (q1.size() != 0 || q3.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_empty: got %0d/%0d pending beats, required 0/0", q1.size(), q3.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
